// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave frame front-end: collects a 2-bit command plus payload from MOSI,
// presents it to the RAM-side controller, and shifts read data back out on MISO.
module spi_slave_frame_ctrl #(
    parameter int PAY_W     = 8,
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [PAY_W+1:0]  rx_data,
    output logic              rx_valid,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ack,
    output logic              frame_err
);

    localparam int FRAME_W = PAY_W + 2;
    localparam int MAXN    = (FRAME_W > DATA_W) ? FRAME_W : DATA_W;
    localparam int CW      = $clog2(MAXN + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_TX_WAIT = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      bit_cnt_r;
    logic [FRAME_W-1:0] rx_shift_r;
    logic [DATA_W-1:0]  tx_shift_r;
    logic               miso_r;
    logic [FRAME_W-1:0] rx_data_r;
    logic               rx_valid_r;
    logic               tx_ack_r;
    logic               frame_err_r;

    logic [CW-1:0]      rx_pos_s;
    logic [FRAME_W-1:0] rx_word_s;
    logic               last_rx_s;
    logic               abort_s;

    // Bit placement for the sample taken this edge, and frame-abort detection.
    always_comb begin
        rx_pos_s = '0;
        if (bit_cnt_r == CW'(1)) begin
            rx_pos_s = CW'(PAY_W);
        end else if (LSB_FIRST) begin
            rx_pos_s = bit_cnt_r - CW'(2);
        end else begin
            rx_pos_s = CW'(PAY_W + 1) - bit_cnt_r;
        end
        rx_word_s = rx_shift_r | ({{(FRAME_W-1){1'b0}}, MOSI} << rx_pos_s);
        last_rx_s = (bit_cnt_r == CW'(FRAME_W - 1));
        abort_s   = SS_n && ((state_r == ST_RX) || (state_r == ST_TX_WAIT) || (state_r == ST_TX));
    end

    // Frame sequencer: owns state, counters, shift registers and every output flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= '0;
            rx_shift_r  <= '0;
            tx_shift_r  <= '0;
            miso_r      <= 1'b0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            tx_ack_r    <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            tx_ack_r    <= 1'b0;
            frame_err_r <= 1'b0;
            if (abort_s) begin
                // Partial frame data is dropped; rx_data keeps the last good word.
                state_r     <= ST_IDLE;
                bit_cnt_r   <= '0;
                rx_shift_r  <= '0;
                tx_shift_r  <= '0;
                miso_r      <= 1'b0;
                frame_err_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        miso_r <= 1'b0;
                        if (!SS_n) begin
                            rx_shift_r <= {MOSI, {(FRAME_W-1){1'b0}}};
                            bit_cnt_r  <= CW'(1);
                            state_r    <= ST_RX;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_RX: begin
                        miso_r <= 1'b0;
                        if (last_rx_s) begin
                            rx_data_r  <= rx_word_s;
                            rx_valid_r <= 1'b1;
                            rx_shift_r <= '0;
                            bit_cnt_r  <= '0;
                            if (rx_word_s[PAY_W+1 -: 2] == 2'b11) begin
                                state_r <= ST_TX_WAIT;
                            end else begin
                                state_r <= ST_DONE;
                            end
                        end else begin
                            rx_shift_r <= rx_word_s;
                            bit_cnt_r  <= bit_cnt_r + CW'(1);
                        end
                    end
                    ST_TX_WAIT: begin
                        if (tx_valid) begin
                            tx_ack_r  <= 1'b1;
                            bit_cnt_r <= CW'(1);
                            state_r   <= ST_TX;
                            if (LSB_FIRST) begin
                                miso_r     <= tx_data[0];
                                tx_shift_r <= tx_data >> 1'b1;
                            end else begin
                                miso_r     <= tx_data[DATA_W-1];
                                tx_shift_r <= tx_data << 1'b1;
                            end
                        end else begin
                            miso_r <= 1'b0;
                        end
                    end
                    ST_TX: begin
                        if (bit_cnt_r < CW'(DATA_W)) begin
                            bit_cnt_r <= bit_cnt_r + CW'(1);
                            if (LSB_FIRST) begin
                                miso_r     <= tx_shift_r[0];
                                tx_shift_r <= tx_shift_r >> 1'b1;
                            end else begin
                                miso_r     <= tx_shift_r[DATA_W-1];
                                tx_shift_r <= tx_shift_r << 1'b1;
                            end
                        end else begin
                            miso_r     <= 1'b0;
                            bit_cnt_r  <= '0;
                            tx_shift_r <= '0;
                            state_r    <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        miso_r <= 1'b0;
                        if (SS_n) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        bit_cnt_r  <= '0;
                        rx_shift_r <= '0;
                        tx_shift_r <= '0;
                        miso_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign MISO      = miso_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign tx_ack    = tx_ack_r;
    assign frame_err = frame_err_r;

endmodule
